// File: rtl/morse_tx_sequencer.sv
// -----------------------------------------------------------------------------
// morse_tx_sequencer
//   Plays a stored message of Morse characters on a buzzer. Each character slot
//   holds a symbol count and a dot/dash pattern. The block sequences marks and
//   gaps with standard unit ratios:
//     dot 1, dash 3, intra-char gap 1, inter-char gap 3, word gap 7.
//   The unit length is U = UNIT_BASE << unit_sel clock cycles.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-low reset
//   start     begin playback (sampled only while idle)
//   abort     stop playback at the next edge, without a done pulse
//   msg_len   characters to play; values above MAX_CHARS clamp to MAX_CHARS
//   char_bus  slot i = [8i+7:8i]: [7:5] symbol count, [4:0] pattern,
//             bit0 played first, 1 = dash, symbol count 0 = word space
//   unit_sel  unit length select
//   tone      buzzer enable, high only during a mark
//   busy      high whenever the sequencer is not idle
//   done      one-cycle pulse on normal completion
//   char_idx  index of the character being played (0 when idle)
// -----------------------------------------------------------------------------
module morse_tx_sequencer #(
  parameter int unsigned UNIT_BASE = 5_000_000,
  parameter int unsigned MAX_CHARS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [3:0]             msg_len,
  input  logic [8*MAX_CHARS-1:0] char_bus,
  input  logic [1:0]             unit_sel,
  output logic                   tone,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             char_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MARK,
    S_GAP_SYM,
    S_GAP_CHAR,
    S_DONE
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_CHARS);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;          // cycles spent in the current state
  logic [31:0] lim_q, lim_d;          // last count value of the current state
  logic [31:0] unit_q, unit_d;        // latched unit length U
  logic [3:0]  char_idx_q, char_idx_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  sym_cnt_q, sym_cnt_d;
  logic [2:0]  sym_idx_q, sym_idx_d;
  logic [4:0]  pat_q, pat_d;
  logic        tone_q, tone_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  slots_q [MAX_CHARS];
  logic        load_slots;
  logic [7:0]  cur_slot;
  logic [2:0]  cur_sym_cnt;
  logic [4:0]  next_pat;
  logic        expired;
  logic        more_sym;
  logic        more_chr;

  // Last counter value for a span of 'units' unit lengths. With 'early' set
  // the span ends one cycle sooner: the following 1-cycle LOAD is silent too,
  // so it supplies the final cycle of the gap and audible spacing stays an
  // exact multiple of U.
  function automatic logic [31:0] span(input logic [2:0] units,
                                       input logic [31:0] u,
                                       input logic early);
    span = 32'(units) * u - 32'd1 - {31'd0, early};
  endfunction

  function automatic logic [2:0] mark_units(input logic is_dash);
    mark_units = is_dash ? 3'd3 : 3'd1;
  endfunction

  // Local copy of the message, captured when playback starts.
  // NOTE: the slot copy is pure datapath storage that is always written
  // before it is read, so it is deliberately left out of the reset.
  always_ff @(posedge clk) begin
    if (load_slots) begin
      for (int i = 0; i < int'(MAX_CHARS); i++) begin
        slots_q[i] <= char_bus[8*i +: 8];
      end
    end
  end

  always_comb begin
    cur_slot = 8'd0;
    for (int i = 0; i < int'(MAX_CHARS); i++) begin
      if (char_idx_q == 4'(i)) cur_slot = slots_q[i];
    end
  end

  assign cur_sym_cnt = (cur_slot[7:5] > 3'd5) ? 3'd5 : cur_slot[7:5];
  assign expired     = (cnt_q == lim_q);
  assign more_sym    = ({1'b0, sym_idx_q} + 4'd1) < {1'b0, sym_cnt_q};
  assign more_chr    = ({1'b0, char_idx_q} + 5'd1) < {1'b0, len_q};
  assign next_pat    = pat_q >> (sym_idx_q + 3'd1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, with blocking
    // assignments, so no path can leave a value unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    lim_d      = lim_q;
    unit_d     = unit_q;
    char_idx_d = char_idx_q;
    len_d      = len_q;
    sym_cnt_d  = sym_cnt_q;
    sym_idx_d  = sym_idx_q;
    pat_d      = pat_q;
    load_slots = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        char_idx_d = 4'd0;
        if (start && !abort) begin
          load_slots = 1'b1;
          len_d      = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
          unit_d     = 32'(UNIT_BASE) << unit_sel;
          state_d    = (len_d != 4'd0) ? S_LOAD : S_DONE;
        end
      end

      S_LOAD: begin
        pat_d     = cur_slot[4:0];
        sym_cnt_d = cur_sym_cnt;
        sym_idx_d = 3'd0;
        if (cur_sym_cnt == 3'd0) begin
          // Word space: silence only, early finish if another LOAD follows.
          state_d = S_GAP_CHAR;
          lim_d   = span(3'd7, unit_q, more_chr);
        end else begin
          state_d = S_MARK;
          lim_d   = span(mark_units(cur_slot[0]), unit_q, 1'b0);
        end
      end

      S_MARK: begin
        if (expired) begin
          if (more_sym) begin
            state_d = S_GAP_SYM;
            lim_d   = span(3'd1, unit_q, 1'b0);
          end else if (more_chr) begin
            state_d = S_GAP_CHAR;
            lim_d   = span(3'd3, unit_q, 1'b1);
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_GAP_SYM: begin
        if (expired) begin
          sym_idx_d = sym_idx_q + 3'd1;
          state_d   = S_MARK;
          lim_d     = span(mark_units(next_pat[0]), unit_q, 1'b0);
        end
      end

      S_GAP_CHAR: begin
        if (expired) begin
          char_idx_d = char_idx_q + 4'd1;
          state_d    = more_chr ? S_LOAD : S_DONE;
        end
      end

      S_DONE: begin
        char_idx_d = 4'd0;
        state_d    = S_IDLE;
      end

      default: begin
        char_idx_d = 4'd0;
        state_d    = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      char_idx_d = 4'd0;
    end

    // The duration counter restarts from zero on every state entry.
    if ((state_d != state_q) || (state_q == S_IDLE)) cnt_d = 32'd0;

    tone_d = (state_d == S_MARK);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values computed before the edge, independent of process order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      lim_q      <= 32'd0;
      unit_q     <= 32'd0;
      char_idx_q <= 4'd0;
      len_q      <= 4'd0;
      sym_cnt_q  <= 3'd0;
      sym_idx_q  <= 3'd0;
      pat_q      <= 5'd0;
      tone_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lim_q      <= lim_d;
      unit_q     <= unit_d;
      char_idx_q <= char_idx_d;
      len_q      <= len_d;
      sym_cnt_q  <= sym_cnt_d;
      sym_idx_q  <= sym_idx_d;
      pat_q      <= pat_d;
      tone_q     <= tone_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tone     = tone_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign char_idx = char_idx_q;

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_morse_tx_sequencer
//   Scoreboard bench. Stimulus pushes the expected playback events (tone run
//   lengths with the character index, silent gaps between marks, done or
//   abort with the total busy length) into a queue; an independent monitor
//   turns the DUT outputs into the same events and compares them in order.
//   U = 4 cycles at unit_sel = 0; MAX_CHARS = 4 so length clamping is cheap.
// -----------------------------------------------------------------------------
module tb_morse_tx_sequencer;

  localparam int unsigned UNIT_BASE = 4;
  localparam int unsigned MAX_CHARS = 4;

  localparam logic [3:0] K_TONE  = 4'd1;
  localparam logic [3:0] K_GAP   = 4'd2;
  localparam logic [3:0] K_DONE  = 4'd3;
  localparam logic [3:0] K_ABORT = 4'd4;

  localparam logic [7:0] CH_E  = 8'b001_00000;
  localparam logic [7:0] CH_A  = 8'b010_00010;
  localparam logic [7:0] CH_T  = 8'b001_00001;
  localparam logic [7:0] CH_SP = 8'b000_00000;
  localparam logic [7:0] CH_5D = 8'b111_00000;   // count 7, clamps to 5 dots

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [3:0]             msg_len = 4'd0;
  logic [8*MAX_CHARS-1:0] char_bus = '0;
  logic [1:0]             unit_sel = 2'd0;
  logic                   tone;
  logic                   busy;
  logic                   done;
  logic [3:0]             char_idx;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  morse_tx_sequencer #(
    .UNIT_BASE(UNIT_BASE),
    .MAX_CHARS(MAX_CHARS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .msg_len  (msg_len),
    .char_bus (char_bus),
    .unit_sel (unit_sel),
    .tone     (tone),
    .busy     (busy),
    .done     (done),
    .char_idx (char_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] ev(input logic [3:0] kind, input logic [3:0] idx,
                                     input int len);
    ev = {8'd0, kind, idx, 16'(len)};
  endfunction

  function automatic void expect_ev(input logic [3:0] kind, input logic [3:0] idx,
                                    input int len);
    exp_q.push_back(ev(kind, idx, len));
  endfunction

  // ---------------------------------------------------------------- monitor
  logic prev_tone = 1'b0;
  logic prev_busy = 1'b0;
  logic had_mark  = 1'b0;
  logic saw_done  = 1'b0;
  int   hi_cnt    = 0;
  int   lo_cnt    = 0;
  int   busy_cnt  = 0;
  logic [3:0] mark_idx = 4'd0;

  task automatic score(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check("unexpected_event", got, 32'd0);
    end else begin
      check("event", got, exp_q.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (tone === 1'b1) begin
      if (!prev_tone) begin
        if (had_mark) score(ev(K_GAP, 4'd0, lo_cnt));
        hi_cnt   = 0;
        mark_idx = char_idx;
      end
      hi_cnt++;
      had_mark = 1'b1;
    end else begin
      if (prev_tone) begin
        score(ev(K_TONE, mark_idx, hi_cnt));
        lo_cnt = 0;
      end
      lo_cnt++;
    end
    if (done === 1'b1) begin
      score(ev(K_DONE, 4'd0, busy_cnt));
      saw_done = 1'b1;
    end
    if (prev_busy && (busy !== 1'b1)) begin
      if (!saw_done) score(ev(K_ABORT, 4'd0, busy_cnt));
      busy_cnt = 0;
      had_mark = 1'b0;
      saw_done = 1'b0;
    end
    prev_tone = (tone === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  // --------------------------------------------------------------- stimulus
  task automatic kick(input logic [8*MAX_CHARS-1:0] bus, input logic [3:0] len,
                      input logic [1:0] usel);
    @(negedge clk);
    char_bus = bus;
    msg_len  = len;
    unit_sel = usel;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (((exp_q.size() != 0) || (busy === 1'b1)) && (cyc < 400)) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 400) begin
      check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    #1;
    check({name, "_idle_idx"}, 32'(char_idx), 32'd0);
  endtask

  task automatic wait_tone(input string name);
    int cyc;
    cyc = 0;
    while ((tone !== 1'b1) && (cyc < 50)) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 50) check({name, "_no_tone"}, 32'(tone), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_tone", 32'(tone), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx",  32'(char_idx), 32'd0);
    rst = 1'b1;

    // 'E': one dot, then done.
    expect_ev(K_TONE, 4'd0, 4);
    expect_ev(K_DONE, 4'd0, 6);
    kick({24'd0, CH_E}, 4'd1, 2'd0);
    drain("e");

    // 'A': dot, gap, dash. Inputs scrambled and start re-pulsed mid-play.
    expect_ev(K_TONE, 4'd0, 4);
    expect_ev(K_GAP,  4'd0, 4);
    expect_ev(K_TONE, 4'd0, 12);
    expect_ev(K_DONE, 4'd0, 22);
    kick({24'd0, CH_A}, 4'd1, 2'd0);
    char_bus = '1;
    msg_len  = 4'd4;
    unit_sel = 2'd3;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("a");

    // "EE": inter-character gap of 3U, char_idx advances.
    expect_ev(K_TONE, 4'd0, 4);
    expect_ev(K_GAP,  4'd0, 12);
    expect_ev(K_TONE, 4'd1, 4);
    expect_ev(K_DONE, 4'd0, 22);
    kick({16'd0, CH_E, CH_E}, 4'd2, 2'd0);
    drain("ee");

    // "E E" with a word space: 3U + 7U of silence.
    expect_ev(K_TONE, 4'd0, 4);
    expect_ev(K_GAP,  4'd0, 40);
    expect_ev(K_TONE, 4'd2, 4);
    expect_ev(K_DONE, 4'd0, 50);
    kick({8'd0, CH_E, CH_SP, CH_E}, 4'd3, 2'd0);
    drain("word_space");

    // Word space as the final character: full 7U of trailing silence.
    expect_ev(K_TONE, 4'd0, 4);
    expect_ev(K_DONE, 4'd0, 46);
    kick({16'd0, CH_SP, CH_E}, 4'd2, 2'd0);
    drain("final_space");

    // 'T' at unit_sel=2: U=16, dash = 48 cycles.
    expect_ev(K_TONE, 4'd0, 48);
    expect_ev(K_DONE, 4'd0, 50);
    kick({24'd0, CH_T}, 4'd1, 2'd2);
    drain("t_slow");

    // Symbol count 7 clamps to 5 dots.
    for (int i = 0; i < 5; i++) begin
      expect_ev(K_TONE, 4'd0, 4);
      if (i < 4) expect_ev(K_GAP, 4'd0, 4);
    end
    expect_ev(K_DONE, 4'd0, 38);
    kick({24'd0, CH_5D}, 4'd1, 2'd0);
    drain("sym_clamp");

    // msg_len=9 clamps to MAX_CHARS=4.
    for (int i = 0; i < 4; i++) begin
      expect_ev(K_TONE, 4'(i), 4);
      if (i < 3) expect_ev(K_GAP, 4'd0, 12);
    end
    expect_ev(K_DONE, 4'd0, 54);
    kick({CH_E, CH_E, CH_E, CH_E}, 4'd9, 2'd0);
    drain("len_clamp");

    // msg_len=0: done right after start, no tone.
    expect_ev(K_DONE, 4'd0, 1);
    kick({24'd0, CH_E}, 4'd0, 2'd0);
    drain("len_zero");

    // start and abort together in IDLE: nothing happens.
    @(negedge clk);
    char_bus = {24'd0, CH_E};
    msg_len  = 4'd1;
    start    = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    abort    = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_tone", 32'(tone), 32'd0);

    // Abort 5 cycles into a dash: no done pulse.
    expect_ev(K_TONE,  4'd0, 5);
    expect_ev(K_ABORT, 4'd0, 6);
    kick({24'd0, CH_T}, 4'd1, 2'd0);
    wait_tone("abort");
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    drain("abort");

    // Reset low mid-mark: everything clears at the next edge.
    expect_ev(K_TONE,  4'd0, 3);
    expect_ev(K_ABORT, 4'd0, 4);
    kick({24'd0, CH_T}, 4'd1, 2'd0);
    wait_tone("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_outs", {28'd0, tone, busy, done, 1'b0} | 32'(char_idx), 32'd0);
    rst = 1'b1;
    drain("reset");

    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
